tx_buf_ctrl: RTL and testbench
==============================

TX_BUF_CTRL -- requirements
Module: tx_buf_ctrl

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst_n  input  1  reset, synchronous, active-low.
REQ-003 en  input  1  block enable; low blocks new word acceptance.
REQ-004 in_data  input  32  word to transmit, LSB sent first.
REQ-005 in_valid  input  1  in_data valid.
REQ-006 in_ready  output  1  word accepted on a clock edge with in_valid=1 and in_ready=1.
REQ-007 TXIn  output  32  registered copy of the accepted word, driven to the downstream shifter.
REQ-008 CSTX  output  1  downstream shifter chip select.
REQ-009 LoadTXBuf0 / LoadTXBuf1  output  1 each  one-cycle load strobes for buffers 0 and 1.
REQ-010 ShiftTXBuf0 / ShiftTXBuf1  output  1 each  per-bit shift strobes for buffers 0 and 1.
REQ-011 busy  output  1  high while a word is being shifted.
REQ-012 word_done  output  1  one-cycle pulse on the cycle carrying the 32nd shift strobe of a word.
REQ-013 underrun  output  1  sticky underrun flag (see Configuration).
REQ-014 underrun_clr  input  1  clears underrun.

Function
REQ-015 Internal state: full0 and full1 flags, wr_ptr and rd_ptr (1 bit each), 5-bit bit_cnt, FSM {IDLE, SHIFT}.
REQ-016 in_ready SHALL equal en AND NOT full[wr_ptr], combinationally.
REQ-017 On acceptance at edge N: TXIn<=in_data; full[wr_ptr]<=1; wr_ptr toggles; LoadTXBuf[wr_ptr] is high for exactly the cycle after edge N.
REQ-018 The two load strobes are never high together; the two shift strobes are never high together.
REQ-019 IDLE->SHIFT when full[rd_ptr]=1 and no load strobe is active for buffer rd_ptr in the current cycle; bit_cnt<=0.
REQ-020 In SHIFT, ShiftTXBuf[rd_ptr] is high every cycle, bit_cnt increments, busy=1; 32 consecutive strobes per word, no gaps.
REQ-021 When bit_cnt=31: word_done=1; full[rd_ptr]<=0 and rd_ptr toggles at that edge; if the other buffer is full and not currently loading, SHIFT continues with bit_cnt=0 (back-to-back, zero idle cycles); otherwise go to IDLE.
REQ-022 Word order: buffer 0 first after reset, then strict alternation; latency from acceptance edge to first shift strobe is 2 cycles when idle.
REQ-023 A load to one buffer and a shift of the other in the same cycle are legal and required for ping-pong operation.
REQ-024 Acceptance on the same edge that frees a buffer SHALL NOT occur: full clears at that edge, so in_ready rises one cycle later.
REQ-025 CSTX SHALL be registered (en OR busy OR any load strobe pending); it stays high until the current word completes even if en falls mid-word.
REQ-026 en=0 mid-word: the current word and any already-full buffer still shift out; no new words are accepted.

Reset
REQ-027 rst_n=0 at an edge: full0=full1=0, wr_ptr=rd_ptr=0, bit_cnt=0, FSM=IDLE, TXIn=0; all strobes, CSTX, busy, word_done and underrun=0. Reset mid-word aborts the word immediately, with no further strobes.

Configuration
REQ-028 Macro TX_BUF_CTRL_UNDERRUN_EN defined: underrun is set on the word_done cycle when the other buffer is not full and en=1; it is cleared by underrun_clr=1, and set has priority over clear.
REQ-029 Macro undefined: underrun is tied to 0 and underrun_clr is ignored; all other behaviour is identical.

Verification
REQ-030 Reset, en=1, one word 0xA5A5_0001 accepted at edge 0: LoadTXBuf0 high in cycle 1; ShiftTXBuf0 high in cycles 2-33; word_done high in cycle 33; busy low in cycle 34.
REQ-031 Continuous in_valid with words W0..W3: loads alternate 0,1,0,1; shift strobes are contiguous for 128 cycles; in_ready low while both buffers are full.
REQ-032 Both buffers full and en dropped: both words complete; CSTX falls after the second word_done; in_ready stays 0.
REQ-033 rst_n pulsed low at bit_cnt=10: no strobes from the next cycle; all outputs at reset values; a new word restarts at buffer 0.
REQ-034 With the macro defined, single word then no input: underrun=1 after word_done and held; underrun_clr pulse clears it. With the macro undefined, underrun stays 0.

Source files
------------

// File: rtl/tx_buf_ctrl.sv
// Ping-pong transmit buffer controller: accepts 32-bit words into two buffers and
// sequences load/shift strobes for the downstream shifter. Define TX_BUF_CTRL_UNDERRUN_EN for the sticky underrun flag.
module tx_buf_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] TXIn,
    output logic        CSTX,
    output logic        LoadTXBuf0,
    output logic        LoadTXBuf1,
    output logic        ShiftTXBuf0,
    output logic        ShiftTXBuf1,
    output logic        busy,
    output logic        word_done,
    output logic        underrun,
    input  logic        underrun_clr
);
    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    state_t     state, state_nx;
    logic [1:0] full, load_q;
    logic       wr_ptr, rd_ptr;
    logic [4:0] bit_cnt;
    logic       accept, last_bit;

    assign in_ready    = en & ~full[wr_ptr];
    assign accept      = in_valid & in_ready;
    assign busy        = (state == SHIFT);
    assign last_bit    = (bit_cnt == 5'd31);
    assign word_done   = busy & last_bit;
    assign ShiftTXBuf0 = busy & ~rd_ptr;
    assign ShiftTXBuf1 = busy & rd_ptr;
    assign LoadTXBuf0  = load_q[0];
    assign LoadTXBuf1  = load_q[1];

    // A buffer being written at this edge never starts shifting at the same edge,
    // so its shift strobes always follow its load strobe.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:
                if (full[rd_ptr] && !(accept && wr_ptr == rd_ptr))
                    state_nx = SHIFT;
            SHIFT:
                if (last_bit)
                    state_nx = (full[~rd_ptr] && !(accept && wr_ptr == ~rd_ptr)) ? SHIFT : IDLE;
            default:
                state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            full    <= '0;
            load_q  <= '0;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            bit_cnt <= '0;
            TXIn    <= '0;
            CSTX    <= 1'b0;
        end else begin
            state   <= state_nx;
            load_q  <= '0;
            // Wraps 31 -> 0 so back-to-back words need no reload.
            bit_cnt <= busy ? bit_cnt + 5'd1 : 5'd0;
            CSTX    <= en | busy | (|full) | (|load_q);
            if (accept) begin
                TXIn           <= in_data;
                full[wr_ptr]   <= 1'b1;
                load_q[wr_ptr] <= 1'b1;
                wr_ptr         <= ~wr_ptr;
            end
            if (word_done) begin
                full[rd_ptr] <= 1'b0;
                rd_ptr       <= ~rd_ptr;
            end
        end
    end

`ifdef TX_BUF_CTRL_UNDERRUN_EN
    always_ff @(posedge clk) begin
        if (!rst_n)
            underrun <= 1'b0;
        else if (word_done && !full[~rd_ptr] && en)
            underrun <= 1'b1;
        else if (underrun_clr)
            underrun <= 1'b0;
    end
`else
    logic unused_underrun_clr;
    assign unused_underrun_clr = underrun_clr;
    assign underrun            = 1'b0;
`endif

endmodule

// File: tb/tb_tx_buf_ctrl.sv
// Self-checking bench for tx_buf_ctrl: per-word schedule model (accept/start/done cycles) plus directed checks.
module tb_tx_buf_ctrl;
    logic        clk = 1'b0;
    logic        rst_n, en, in_valid, underrun_clr;
    logic [31:0] in_data;
    logic        in_ready, CSTX, LoadTXBuf0, LoadTXBuf1, ShiftTXBuf0, ShiftTXBuf1;
    logic        busy, word_done, underrun;
    logic [31:0] TXIn;

    tx_buf_ctrl dut (
        .clk(clk), .rst_n(rst_n), .en(en), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .TXIn(TXIn), .CSTX(CSTX),
        .LoadTXBuf0(LoadTXBuf0), .LoadTXBuf1(LoadTXBuf1),
        .ShiftTXBuf0(ShiftTXBuf0), .ShiftTXBuf1(ShiftTXBuf1),
        .busy(busy), .word_done(word_done), .underrun(underrun), .underrun_clr(underrun_clr)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // Word i of the current epoch: accepted in period qa, shifts qs..qd, lives in buffer i%2.
    int          qa[$], qs[$], qd[$];
    logic [31:0] m_txin;
    logic        m_cstx, m_und;
    int          p;
    int          first_done, sh_cnt, sh_first, sh_last, cstx_last;

    function automatic logic exp_ready(input int pp);
        int k;
        k = qa.size();
        return en && (k < 2 || qd[k-2] < pp);
    endfunction

    function automatic logic any_full(input int pp);
        logic f;
        f = 1'b0;
        for (int i = 0; i < qa.size(); i++)
            if (qa[i] < pp && pp <= qd[i]) f = 1'b1;
        return f;
    endfunction

    // {in_ready, load1, load0, shift1, shift0, busy, word_done, cstx, underrun}
    function automatic logic [8:0] expect_vec(input int pp);
        logic ld0, ld1, sh0, sh1, wd;
        ld0 = 1'b0; ld1 = 1'b0; sh0 = 1'b0; sh1 = 1'b0; wd = 1'b0;
        for (int i = 0; i < qa.size(); i++) begin
            if (qa[i] + 1 == pp) begin
                if (i % 2 == 1) ld1 = 1'b1; else ld0 = 1'b1;
            end
            if (qs[i] <= pp && pp <= qd[i]) begin
                if (i % 2 == 1) sh1 = 1'b1; else sh0 = 1'b1;
            end
            if (qd[i] == pp) wd = 1'b1;
        end
        return {exp_ready(pp), ld1, ld0, sh1, sh0, sh0 | sh1, wd, m_cstx, m_und};
    endfunction

    task automatic chk_int(input string tag, input int obs, input int expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Checks the current period at the falling edge, advances the model across the
    // next rising edge, and returns 1 time unit after it.
    task automatic step();
        logic [8:0] ev, ov;
        logic       other, set;
        int         s;
        @(negedge clk);
        ev = expect_vec(p);
        ov = {in_ready, LoadTXBuf1, LoadTXBuf0, ShiftTXBuf1, ShiftTXBuf0, busy, word_done, CSTX, underrun};
        n_chk++;
        assert (ov === ev) else begin
            n_fail++;
            $error("FAIL status p=%0d observed=%b expected=%b", p, ov, ev);
        end
        n_chk++;
        assert (TXIn === m_txin) else begin
            n_fail++;
            $error("FAIL txin p=%0d observed=%h expected=%h", p, TXIn, m_txin);
        end
        n_chk++;
        assert ({LoadTXBuf0 & LoadTXBuf1, ShiftTXBuf0 & ShiftTXBuf1} === 2'b00) else begin
            n_fail++;
            $error("FAIL exclusive p=%0d observed=%b%b%b%b expected=no pair high",
                   p, LoadTXBuf0, LoadTXBuf1, ShiftTXBuf0, ShiftTXBuf1);
        end
        if (ShiftTXBuf0 || ShiftTXBuf1) begin
            sh_cnt++;
            if (sh_first < 0) sh_first = p;
            sh_last = p;
        end
        if (CSTX) cstx_last = p;
        if (word_done && first_done < 0) first_done = p;

        set = 1'b0;
        for (int i = 0; i < qd.size(); i++)
            if (qd[i] == p) begin
                other = (i + 1 < qa.size()) && (qa[i+1] < p);
                set   = !other && en;
            end
        if (in_valid && ev[8]) begin
            s = p + 2;
            if (qd.size() > 0 && qd[$] + 1 > s) s = qd[$] + 1;
            qa.push_back(p);
            qs.push_back(s);
            qd.push_back(s + 31);
            m_txin = in_data;
        end
`ifdef TX_BUF_CTRL_UNDERRUN_EN
        if (set) m_und = 1'b1;
        else if (underrun_clr) m_und = 1'b0;
`else
        m_und = 1'b0 & set;
`endif
        m_cstx = en | ev[4] | any_full(p);
        p++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; in_valid = 1'b0; underrun_clr = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        qa.delete(); qs.delete(); qd.delete();
        p = 0; m_txin = '0; m_cstx = 1'b0; m_und = 1'b0;
        first_done = -1; sh_cnt = 0; sh_first = -1; sh_last = -1; cstx_last = -1;
    endtask

    initial begin
        int words, guard;
        en = 1'b1; in_valid = 1'b0; in_data = '0; underrun_clr = 1'b0; rst_n = 1'b0;

        // Reset state
        do_reset();
        chk_int("reset_outputs",
                int'({LoadTXBuf0, LoadTXBuf1, ShiftTXBuf0, ShiftTXBuf1, busy, word_done, CSTX, underrun}), 0);
        chk_int("reset_txin", int'(TXIn), 0);

        // Single word: load in 1, shift 2..33, done in 33
        in_valid = 1'b1; in_data = 32'hA5A5_0001;
        step();
        in_valid = 1'b0;
        repeat (40) step();
        chk_int("single_done_cycle", first_done, 33);
        chk_int("single_first_shift", sh_first, 2);
        chk_int("single_last_shift", sh_last, 33);
        chk_int("single_shift_count", sh_cnt, 32);
`ifdef TX_BUF_CTRL_UNDERRUN_EN
        chk_int("underrun_held", int'(underrun), 1);
        underrun_clr = 1'b1;
        step();
        underrun_clr = 1'b0;
        chk_int("underrun_cleared", int'(underrun), 0);
        step();
`else
        chk_int("underrun_tied_low", int'(underrun), 0);
        underrun_clr = 1'b1;
        step();
        underrun_clr = 1'b0;
        chk_int("underrun_clr_ignored", int'(underrun), 0);
`endif

        // Continuous stream of four words: 128 contiguous shift strobes
        do_reset();
        in_valid = 1'b1; words = 0; guard = 0;
        while (words < 4 && guard < 500) begin
            in_data = $urandom;
            if (exp_ready(p)) words++;
            guard++;
            step();
        end
        in_valid = 1'b0;
        chk_int("stream_words_accepted", words, 4);
        repeat (140) step();
        chk_int("stream_shift_count", sh_cnt, 128);
        chk_int("stream_contiguous", sh_last - sh_first + 1, 128);

        // Both buffers full, then enable dropped
        do_reset();
        in_valid = 1'b1; in_data = $urandom;
        step();
        in_data = $urandom;
        step();
        en = 1'b0; in_data = $urandom;
        repeat (90) step();
        in_valid = 1'b0; en = 1'b1;
        chk_int("en_drop_shift_count", sh_cnt, 64);
        chk_int("en_drop_cstx_last", cstx_last, 66);

        // Reset while bit_cnt = 10, then a fresh word restarts at buffer 0
        do_reset();
        in_valid = 1'b1; in_data = $urandom;
        step();
        in_valid = 1'b0;
        repeat (11) step();
        chk_int("pre_reset_shifting", int'(ShiftTXBuf0), 1);
        do_reset();
        chk_int("post_reset_strobes",
                int'({LoadTXBuf0, LoadTXBuf1, ShiftTXBuf0, ShiftTXBuf1, busy, CSTX}), 0);
        in_valid = 1'b1; in_data = $urandom;
        step();
        in_valid = 1'b0;
        chk_int("restart_load0", int'({LoadTXBuf1, LoadTXBuf0}), 1);
        repeat (40) step();
        chk_int("restart_first_shift", sh_first, 2);

        // Randomized traffic
        do_reset();
        repeat (800) begin
            en           = ($urandom_range(0, 9) != 0);
            in_valid     = $urandom_range(0, 1) == 1;
            in_data      = $urandom;
            underrun_clr = ($urandom_range(0, 15) == 0);
            step();
        end
        in_valid = 1'b0; underrun_clr = 1'b0; en = 1'b1;
        repeat (80) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
